// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and its datapath.
// The controller side uses the master modport, the datapath side the slave.
interface multicycle_controller_if #(
    parameter int ALUCTR_W = 3,
    parameter int CNT_W    = 32
);
    // Datapath status towards the controller
    logic [5:0]          op;
    logic [5:0]          func;
    logic                zero;
    logic                mem_ready;

    // Control strobes and selects from the controller
    logic                PcWr;
    logic                IrWr;
    logic                MemRd;
    logic                MemWr;
    logic                RegWr;
    logic                RegDst;
    logic                MemtoReg;
    logic                ExtOP;
    logic                AluSrcA;
    logic [1:0]          AluSrcB;
    logic [1:0]          PcSrc;
    logic [ALUCTR_W-1:0] AluCtr;
    logic [2:0]          State;
    logic                InstrDone;
    logic                Illegal;
    logic [CNT_W-1:0]    InstrCnt;

    modport master (
        input  op, func, zero, mem_ready,
        output PcWr, IrWr, MemRd, MemWr, RegWr, RegDst, MemtoReg, ExtOP,
               AluSrcA, AluSrcB, PcSrc, AluCtr, State, InstrDone, Illegal,
               InstrCnt
    );

    modport slave (
        output op, func, zero, mem_ready,
        input  PcWr, IrWr, MemRd, MemWr, RegWr, RegDst, MemtoReg, ExtOP,
               AluSrcA, AluSrcB, PcSrc, AluCtr, State, InstrDone, Illegal,
               InstrCnt
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control unit: Moore FSM IF/ID/EX/MEM/WB with
// opcode/func decode and a retired-instruction counter.
// Optional build macro MC_MEMWAIT_EN: IF and MEM stall while mem_ready is low.
// Control outputs are decoded from the current state so they line up with the
// datapath cycle they control; strobes are forced low while rst is high.
module multicycle_controller #(
    parameter int ALUCTR_W = 3,
    parameter int CNT_W    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    multicycle_controller_if.master   bus
);
    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EX  = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [2:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                is_r_s, is_j_s, is_beq_s, is_addiu_s, is_ori_s;
    logic                is_lw_s, is_sw_s, op_ok_s, func_ok_s;
    logic [2:0]          func_alu_s;
    logic                mem_ok_s;

    logic                pc_wr_s, ir_wr_s, mem_rd_s, mem_wr_s, reg_wr_s;
    logic                reg_dst_s, mem_to_reg_s, alu_src_a_s;
    logic [1:0]          alu_src_b_s, pc_src_s;
    logic [2:0]          alu3_s;
    logic [ALUCTR_W-1:0] alu_ctr_s;
    logic                done_s, illegal_s;

`ifdef MC_MEMWAIT_EN
    assign mem_ok_s = bus.mem_ready;
`else
    // mem_ready has no effect in this build; every state lasts one cycle.
    logic unused_mem_ready_s;
    assign unused_mem_ready_s = bus.mem_ready;
    assign mem_ok_s           = 1'b1;
`endif

    assign is_r_s     = (bus.op == OP_R);
    assign is_j_s     = (bus.op == OP_J);
    assign is_beq_s   = (bus.op == OP_BEQ);
    assign is_addiu_s = (bus.op == OP_ADDIU);
    assign is_ori_s   = (bus.op == OP_ORI);
    assign is_lw_s    = (bus.op == OP_LW);
    assign is_sw_s    = (bus.op == OP_SW);
    assign op_ok_s    = is_r_s | is_j_s | is_beq_s | is_addiu_s | is_ori_s |
                        is_lw_s | is_sw_s;

    // R-type function field to ALU operation, flagging unsupported codes
    always_comb begin
        func_alu_s = ALU_ADD;
        func_ok_s  = 1'b1;
        case (bus.func)
            6'b100000: func_alu_s = ALU_ADD;
            6'b100010: func_alu_s = ALU_SUB;
            6'b100100: func_alu_s = ALU_AND;
            6'b100101: func_alu_s = ALU_OR;
            6'b101010: func_alu_s = ALU_SLT;
            default: begin
                func_alu_s = ALU_ADD;
                func_ok_s  = 1'b0;
            end
        endcase
    end

    // Next-state and per-state control decode
    always_comb begin
        state_d      = S_IF;
        pc_wr_s      = 1'b0;
        ir_wr_s      = 1'b0;
        mem_rd_s     = 1'b0;
        mem_wr_s     = 1'b0;
        reg_wr_s     = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = 2'b00;
        pc_src_s     = 2'b00;
        alu3_s       = ALU_ADD;
        done_s       = 1'b0;
        illegal_s    = 1'b0;
        case (state_q)
            S_IF: begin
                mem_rd_s    = 1'b1;
                alu_src_b_s = 2'b01;
                if (mem_ok_s) begin
                    ir_wr_s = 1'b1;
                    pc_wr_s = 1'b1;
                    state_d = S_ID;
                end else begin
                    state_d = S_IF;
                end
            end
            S_ID: begin
                alu_src_b_s = 2'b11;
                if (is_j_s) begin
                    pc_wr_s  = 1'b1;
                    pc_src_s = 2'b10;
                    done_s   = 1'b1;
                    state_d  = S_IF;
                end else if (!op_ok_s || (is_r_s && !func_ok_s)) begin
                    illegal_s = 1'b1;
                    state_d   = S_IF;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                if (is_r_s) begin
                    alu_src_a_s = 1'b1;
                    alu3_s      = func_alu_s;
                    state_d     = S_WB;
                end else if (is_addiu_s || is_ori_s) begin
                    alu_src_a_s = 1'b1;
                    alu_src_b_s = 2'b10;
                    alu3_s      = is_ori_s ? ALU_OR : ALU_ADD;
                    state_d     = S_WB;
                end else if (is_lw_s || is_sw_s) begin
                    alu_src_a_s = 1'b1;
                    alu_src_b_s = 2'b10;
                    state_d     = S_MEM;
                end else if (is_beq_s) begin
                    alu_src_a_s = 1'b1;
                    alu3_s      = ALU_SUB;
                    pc_src_s    = 2'b01;
                    pc_wr_s     = bus.zero;
                    done_s      = 1'b1;
                    state_d     = S_IF;
                end else begin
                    state_d = S_IF;
                end
            end
            S_MEM: begin
                if (is_lw_s) begin
                    mem_rd_s = 1'b1;
                    state_d  = mem_ok_s ? S_WB : S_MEM;
                end else if (is_sw_s) begin
                    mem_wr_s = 1'b1;
                    if (mem_ok_s) begin
                        done_s  = 1'b1;
                        state_d = S_IF;
                    end else begin
                        state_d = S_MEM;
                    end
                end else begin
                    state_d = S_IF;
                end
            end
            S_WB: begin
                reg_wr_s     = 1'b1;
                reg_dst_s    = is_r_s;
                mem_to_reg_s = is_lw_s;
                done_s       = 1'b1;
                state_d      = S_IF;
            end
            default: begin
                state_d = S_IF;
            end
        endcase
    end

    // Widen the 3-bit ALU code; upper bits stay zero
    always_comb begin
        alu_ctr_s      = '0;
        alu_ctr_s[2:0] = alu3_s;
    end

    // Retired-instruction counter next value, wrapping naturally
    always_comb begin
        if (done_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and counter registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strobes are masked by rst so a write in progress drops immediately
    assign bus.PcWr      = pc_wr_s   & ~rst;
    assign bus.IrWr      = ir_wr_s   & ~rst;
    assign bus.MemRd     = mem_rd_s  & ~rst;
    assign bus.MemWr     = mem_wr_s  & ~rst;
    assign bus.RegWr     = reg_wr_s  & ~rst;
    assign bus.InstrDone = done_s    & ~rst;
    assign bus.Illegal   = illegal_s & ~rst;
    assign bus.RegDst    = reg_dst_s;
    assign bus.MemtoReg  = mem_to_reg_s;
    assign bus.ExtOP     = ~is_ori_s;
    assign bus.AluSrcA   = alu_src_a_s;
    assign bus.AluSrcB   = alu_src_b_s;
    assign bus.PcSrc     = pc_src_s;
    assign bus.AluCtr    = alu_ctr_s;
    assign bus.State     = state_q;
    assign bus.InstrCnt  = cnt_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller: a default instance plus a
// CNT_W=4 instance sharing all inputs for the counter wrap check.
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = 6'b000000;
    logic [5:0] func = 6'b100010;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    int         n_tests = 0;
    int         n_fail = 0;

    multicycle_controller_if #(.ALUCTR_W(3), .CNT_W(32)) bus_s ();
    multicycle_controller_if #(.ALUCTR_W(3), .CNT_W(4))  bus_small_s ();

    assign bus_s.op              = op;
    assign bus_s.func            = func;
    assign bus_s.zero            = zero;
    assign bus_s.mem_ready       = mem_ready;
    assign bus_small_s.op        = op;
    assign bus_small_s.func      = func;
    assign bus_small_s.zero      = zero;
    assign bus_small_s.mem_ready = mem_ready;

    multicycle_controller #(.ALUCTR_W(3), .CNT_W(32)) dut (
        .clk (clk), .rst (rst), .bus (bus_s)
    );
    multicycle_controller #(.ALUCTR_W(3), .CNT_W(4)) dut_small (
        .clk (clk), .rst (rst), .bus (bus_small_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one clock and settle between edges
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // ---- reset state ----
        #2;
        chk("rst_state", 32'(bus_s.State), 32'd0);
        chk("rst_cnt", bus_s.InstrCnt, 32'd0);
        chk("rst_memrd", 32'(bus_s.MemRd), 32'd0);
        chk("rst_pcwr", 32'(bus_s.PcWr), 32'd0);
        chk("rst_irwr", 32'(bus_s.IrWr), 32'd0);
        cyc();
        chk("rst_hold_state", 32'(bus_s.State), 32'd0);
        rst = 1'b0;
        #1;

        // ---- R-type sub ----
        chk("r_if_state", 32'(bus_s.State), 32'd0);
        chk("r_if_memrd", 32'(bus_s.MemRd), 32'd1);
        chk("r_if_irwr", 32'(bus_s.IrWr), 32'd1);
        chk("r_if_pcwr", 32'(bus_s.PcWr), 32'd1);
        chk("r_if_srcb", 32'(bus_s.AluSrcB), 32'd1);
        cyc();
        chk("r_id_state", 32'(bus_s.State), 32'd1);
        chk("r_id_srcb", 32'(bus_s.AluSrcB), 32'd3);
        chk("r_id_pcwr", 32'(bus_s.PcWr), 32'd0);
        cyc();
        chk("r_ex_state", 32'(bus_s.State), 32'd2);
        chk("r_ex_aluctr", 32'(bus_s.AluCtr), 32'd4);
        chk("r_ex_srca", 32'(bus_s.AluSrcA), 32'd1);
        chk("r_ex_srcb", 32'(bus_s.AluSrcB), 32'd0);
        cyc();
        chk("r_wb_state", 32'(bus_s.State), 32'd4);
        chk("r_wb_regwr", 32'(bus_s.RegWr), 32'd1);
        chk("r_wb_regdst", 32'(bus_s.RegDst), 32'd1);
        chk("r_wb_done", 32'(bus_s.InstrDone), 32'd1);
        cyc();
        chk("r_next_state", 32'(bus_s.State), 32'd0);
        chk("r_cnt", bus_s.InstrCnt, 32'd1);

        // ---- ori ----
        op = 6'b001101;
        #1;
        chk("ori_extop", 32'(bus_s.ExtOP), 32'd0);
        cyc();
        cyc();
        chk("ori_ex_aluctr", 32'(bus_s.AluCtr), 32'd2);
        chk("ori_ex_srcb", 32'(bus_s.AluSrcB), 32'd2);
        cyc();
        chk("ori_wb_state", 32'(bus_s.State), 32'd4);
        chk("ori_wb_regdst", 32'(bus_s.RegDst), 32'd0);
        chk("ori_wb_regwr", 32'(bus_s.RegWr), 32'd1);
        cyc();
        chk("ori_cnt", bus_s.InstrCnt, 32'd2);

        // ---- lw with memory stalled in MEM ----
        op = 6'b100011;
        #1;
        chk("lw_extop", 32'(bus_s.ExtOP), 32'd1);
        cyc();
        cyc();
        chk("lw_ex_state", 32'(bus_s.State), 32'd2);
        mem_ready = 1'b0;
        cyc();
        chk("lw_mem_state", 32'(bus_s.State), 32'd3);
        chk("lw_mem_memrd", 32'(bus_s.MemRd), 32'd1);
`ifdef MC_MEMWAIT_EN
        cyc();
        chk("lw_wait1_state", 32'(bus_s.State), 32'd3);
        chk("lw_wait1_memrd", 32'(bus_s.MemRd), 32'd1);
        cyc();
        chk("lw_wait2_state", 32'(bus_s.State), 32'd3);
        mem_ready = 1'b1;
        #1;
        chk("lw_wait_done", 32'(bus_s.InstrDone), 32'd0);
`endif
        cyc();
        chk("lw_wb_state", 32'(bus_s.State), 32'd4);
        chk("lw_wb_memtoreg", 32'(bus_s.MemtoReg), 32'd1);
        chk("lw_wb_regdst", 32'(bus_s.RegDst), 32'd0);
        mem_ready = 1'b1;
        cyc();
        chk("lw_cnt", bus_s.InstrCnt, 32'd3);

        // ---- beq taken ----
        op = 6'b000100;
        zero = 1'b1;
        cyc();
        cyc();
        chk("beq1_ex_pcwr", 32'(bus_s.PcWr), 32'd1);
        chk("beq1_ex_pcsrc", 32'(bus_s.PcSrc), 32'd1);
        chk("beq1_ex_aluctr", 32'(bus_s.AluCtr), 32'd4);
        chk("beq1_ex_done", 32'(bus_s.InstrDone), 32'd1);
        cyc();
        chk("beq1_next_state", 32'(bus_s.State), 32'd0);

        // ---- beq not taken ----
        zero = 1'b0;
        cyc();
        cyc();
        chk("beq0_ex_pcwr", 32'(bus_s.PcWr), 32'd0);
        chk("beq0_ex_done", 32'(bus_s.InstrDone), 32'd1);
        cyc();
        chk("beq0_next_state", 32'(bus_s.State), 32'd0);
        chk("beq_cnt", bus_s.InstrCnt, 32'd5);

        // ---- illegal opcode ----
        op = 6'b111111;
        cyc();
        chk("ill_id_illegal", 32'(bus_s.Illegal), 32'd1);
        chk("ill_id_pcwr", 32'(bus_s.PcWr), 32'd0);
        chk("ill_id_done", 32'(bus_s.InstrDone), 32'd0);
        cyc();
        chk("ill_next_state", 32'(bus_s.State), 32'd0);
        chk("ill_cnt", bus_s.InstrCnt, 32'd5);
        chk("ill_if_illegal", 32'(bus_s.Illegal), 32'd0);

        // ---- R-type with unsupported func ----
        op = 6'b000000;
        func = 6'b000000;
        cyc();
        chk("illf_id_illegal", 32'(bus_s.Illegal), 32'd1);
        cyc();
        chk("illf_next_state", 32'(bus_s.State), 32'd0);
        chk("illf_cnt", bus_s.InstrCnt, 32'd5);
        func = 6'b100010;

        // ---- jump ----
        op = 6'b000010;
        cyc();
        chk("j_id_pcwr", 32'(bus_s.PcWr), 32'd1);
        chk("j_id_pcsrc", 32'(bus_s.PcSrc), 32'd2);
        chk("j_id_done", 32'(bus_s.InstrDone), 32'd1);
        cyc();
        chk("j_next_state", 32'(bus_s.State), 32'd0);
        chk("j_cnt", bus_s.InstrCnt, 32'd6);

        // ---- sw interrupted by reset in MEM ----
        op = 6'b101011;
        cyc();
        cyc();
        cyc();
        chk("sw_mem_state", 32'(bus_s.State), 32'd3);
        chk("sw_mem_memwr", 32'(bus_s.MemWr), 32'd1);
        chk("sw_mem_memrd", 32'(bus_s.MemRd), 32'd0);
        rst = 1'b1;
        #1;
        chk("sw_rst_memwr", 32'(bus_s.MemWr), 32'd0);
        chk("sw_rst_state", 32'(bus_s.State), 32'd0);
        chk("sw_rst_cnt", bus_s.InstrCnt, 32'd0);
        chk("sw_rst_done", 32'(bus_s.InstrDone), 32'd0);
        cyc();
        chk("sw_rst_irwr", 32'(bus_s.IrWr), 32'd0);
        rst = 1'b0;
        #1;
        chk("sw_rel_state", 32'(bus_s.State), 32'd0);
        chk("sw_rel_memrd", 32'(bus_s.MemRd), 32'd1);

        // ---- 16 jumps: narrow counter wraps ----
        op = 6'b000010;
        for (int i = 0; i < 15; i++) begin
            cyc();
            cyc();
        end
        chk("wrap15_small", 32'(bus_small_s.InstrCnt), 32'd15);
        cyc();
        cyc();
        chk("wrap16_small", 32'(bus_small_s.InstrCnt), 32'd0);
        chk("wrap16_main", bus_s.InstrCnt, 32'd16);
        chk("wrap16_state", 32'(bus_s.State), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter ALUCTR_W, default 3: AluCtr width, minimum 3; bits above [2] driven 0.
REQ-002 SHALL have parameter CNT_W, default 32: InstrCnt width.
REQ-003 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  6  opcode, held stable by the IR after IF.
- func  in  6  R-type function field.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete.
- PcWr  out  1  PC write strobe.
- IrWr  out  1  IR write strobe.
- MemRd  out  1  memory read.
- MemWr  out  1  memory write.
- RegWr  out  1  register file write.
- RegDst  out  1  1 = rd, 0 = rt.
- MemtoReg  out  1  1 = memory data to register file.
- ExtOP  out  1  1 = sign-extend, 0 = zero-extend.
- AluSrcA  out  1  0 = PC, 1 = rs.
- AluSrcB  out  2  00 rt, 01 constant 4, 10 immediate, 11 immediate<<2.
- PcSrc  out  2  00 ALU result, 01 ALUOut register, 10 jump target.
- AluCtr  out  ALUCTR_W  ALU operation.
- State  out  3  current state.
- InstrDone  out  1  one-cycle pulse on instruction retire.
- Illegal  out  1  one-cycle pulse on undecodable instruction.
- InstrCnt  out  CNT_W  retired-instruction count.

Function
REQ-004 SHALL implement Moore FSM states IF=0, ID=1, EX=2, MEM=3, WB=4; codes 5-7 SHALL go to IF on the next edge.
REQ-005 SHALL decode: R 000000, j 000010, beq 000100, addiu 001001, ori 001101, lw 100011, sw 101011.
REQ-006 SHALL decode R-type func: add 100000, sub 100010, and 100100, or 100101, slt 101010.
REQ-007 SHALL encode AluCtr as add 000, sub 100, and 001, or 010, slt 111.
REQ-008 SHALL drive ExtOP=0 only for ori, 1 otherwise.
REQ-009 IF SHALL assert MemRd, IrWr, PcWr, AluSrcA=0, AluSrcB=01, PcSrc=00 and AluCtr=add, then go to ID.
REQ-010 ID SHALL drive AluSrcA=0, AluSrcB=11, AluCtr=add; for j it SHALL assert PcWr with PcSrc=10, pulse InstrDone and go to IF.
REQ-011 ID SHALL, on an undecodable op, or a func not in REQ-006 when op=R, pulse Illegal, assert no strobe and go to IF without counting.
REQ-012 EX SHALL behave per class:
- R: AluSrcA=1, AluSrcB=00, AluCtr from func; next WB.
- addiu/ori: AluSrcA=1, AluSrcB=10, AluCtr add/or; next WB.
- lw/sw: AluSrcA=1, AluSrcB=10, add; next MEM.
- beq: AluSrcA=1, AluSrcB=00, sub, PcSrc=01, PcWr=zero, pulse InstrDone; next IF.
REQ-013 MEM SHALL assert MemRd for lw (next WB), or assert MemWr and pulse InstrDone for sw (next IF).
REQ-014 WB SHALL assert RegWr with RegDst=1 for R, MemtoReg=1 for lw, both 0 otherwise; it SHALL pulse InstrDone and go to IF.
REQ-015 Cycles per instruction with no wait states SHALL be: j 2, beq 3, R/addiu/ori/sw 4, lw 5.
REQ-016 InstrCnt SHALL increment by 1 on each InstrDone cycle and wrap from all-ones to 0.
REQ-017 Unused strobes SHALL be 0 in every state; unused selects SHALL be 0.

Reset
REQ-018 rst SHALL asynchronously force State=IF and InstrCnt=0.
REQ-019 While rst=1, PcWr, IrWr, MemRd, MemWr, RegWr, InstrDone and Illegal SHALL be 0.
REQ-020 Reset asserted in any state, including MEM during sw, SHALL immediately deassert MemWr; after release the first edge SHALL begin a fresh IF.

Configuration
REQ-021 With MC_MEMWAIT_EN defined, IF and MEM SHALL hold state while mem_ready=0, keeping MemRd/MemWr asserted.
REQ-022 With MC_MEMWAIT_EN defined, IrWr and PcWr in IF, and InstrDone in sw-MEM, SHALL assert only in the mem_ready=1 cycle.
REQ-023 Without MC_MEMWAIT_EN, mem_ready SHALL be ignored and every state SHALL last exactly one cycle.

Verification
REQ-024 Reset release, then op=000000 func=100010, zero=0: sequence IF,ID,EX,WB; AluCtr=100 in EX; RegWr=1 and RegDst=1 in WB; InstrCnt=1.
REQ-025 op=100011 with MC_MEMWAIT_EN and mem_ready low 2 cycles in MEM: MEM lasts 3 cycles, MemRd held, then WB with MemtoReg=1; total 7 cycles.
REQ-026 op=000100: with zero=1, PcWr=1 and PcSrc=01 in EX; with zero=0, PcWr=0; both reach IF after 3 cycles.
REQ-027 op=111111 (illegal): Illegal pulses in ID, InstrCnt unchanged, next state IF.
REQ-028 rst asserted mid-sw in MEM: MemWr drops the same cycle, State=0, InstrCnt=0; with CNT_W=4, 16 retirements wrap InstrCnt to 0.
